// File: rtl/addr_gen_upd_param.sv
// Read-address sequencer for the LSTM update-parameter stage: streams (dgate, X/H) pairs per weight.
// First pair one cycle after start; i_stall freezes RUN (outputs and counters hold), GAP timing ignores it.
module addr_gen_upd_param #(
  parameter int ADDR_WIDTH = 12,
  parameter int TIMESTEP   = 7,
  parameter int NUM_CELL   = 53,
  parameter int NUM_INPUT  = 53,
  parameter int DELAY      = 1,
  parameter int BASE_D     = 0,
  parameter int BASE_X     = 0,
  parameter int BASE_H     = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic                  i_stall,
  output logic [ADDR_WIDTH-1:0] o_addr_d,
  output logic [ADDR_WIDTH-1:0] o_addr_x,
  output logic                  o_valid,
  output logic                  o_zero,
  output logic                  o_first,
  output logic                  o_last,
  output logic [ADDR_WIDTH-1:0] o_waddr,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] T_LAST   = AW'(TIMESTEP - 1);
  localparam logic [AW-1:0] NC_LAST  = AW'(NUM_CELL - 1);
  localparam logic [AW-1:0] NIN_LAST = AW'(NUM_INPUT - 1);
  localparam logic [AW-1:0] NC_STEP  = AW'(NUM_CELL);
  localparam logic [AW-1:0] NIN_STEP = AW'(NUM_INPUT);
  localparam logic [AW-1:0] BD       = AW'(BASE_D);
  localparam logic [AW-1:0] BX       = AW'(BASE_X);
  localparam logic [AW-1:0] BH       = AW'(BASE_H);
  localparam logic [AW-1:0] GAP_LAST = AW'((DELAY > 0) ? DELAY - 1 : 0);
  localparam bit            HAS_GAP  = (DELAY > 0);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} state_t;

  state_t        state_q;
  logic          mode_q;
  logic [AW-1:0] t_q, i_q, c_q, gap_q;
  logic [AW-1:0] d_run_q, x_run_q;
  logic [AW-1:0] addr_d_q, addr_x_q, waddr_q;
  logic          valid_q, zero_q, first_q, last_q, busy_q, done_q;

  logic [AW-1:0] i_d, c_d, d_run_d, x_run_d, x_step;
  logic          nin_wrap, last_t, last_run;

  // Per-run base addresses advance by one; the t loop then strides from them.
  always_comb begin
    nin_wrap = (i_q == (mode_q ? NC_LAST : NIN_LAST));
    last_t   = (t_q == T_LAST);
    last_run = nin_wrap && (c_q == NC_LAST);
    x_step   = '0;
    if (!mode_q)
      x_step = NIN_STEP;
    else if (t_q != '0)
      x_step = NC_STEP;  // h(-1) and h(0) share row 0, so no stride from t=0 to t=1
    i_d     = i_q + 1'b1;
    c_d     = c_q;
    d_run_d = d_run_q;
    x_run_d = x_run_q + 1'b1;
    if (nin_wrap) begin
      i_d     = '0;
      c_d     = c_q + 1'b1;
      d_run_d = d_run_q + 1'b1;
      x_run_d = mode_q ? BH : BX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      t_q      <= '0;
      i_q      <= '0;
      c_q      <= '0;
      gap_q    <= '0;
      d_run_q  <= '0;
      x_run_q  <= '0;
      addr_d_q <= '0;
      addr_x_q <= '0;
      waddr_q  <= '0;
      valid_q  <= 1'b0;
      zero_q   <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q  <= S_RUN;
            mode_q   <= i_mode;
            t_q      <= '0;
            i_q      <= '0;
            c_q      <= '0;
            d_run_q  <= BD;
            x_run_q  <= i_mode ? BH : BX;
            addr_d_q <= BD;
            addr_x_q <= i_mode ? BH : BX;
            waddr_q  <= '0;
            valid_q  <= 1'b1;
            zero_q   <= i_mode;
            first_q  <= 1'b1;
            last_q   <= 1'b0;
            busy_q   <= 1'b1;
          end
        end
        S_RUN: begin
          if (!i_stall) begin
            if (!last_t) begin
              t_q      <= t_q + 1'b1;
              addr_d_q <= addr_d_q + NC_STEP;
              addr_x_q <= addr_x_q + x_step;
              zero_q   <= 1'b0;
              first_q  <= 1'b0;
              last_q   <= ((t_q + 1'b1) == T_LAST);
            end else if (last_run) begin
              state_q  <= S_DONE;
              t_q      <= '0;
              i_q      <= '0;
              c_q      <= '0;
              d_run_q  <= '0;
              x_run_q  <= '0;
              addr_d_q <= '0;
              addr_x_q <= '0;
              waddr_q  <= '0;
              valid_q  <= 1'b0;
              zero_q   <= 1'b0;
              first_q  <= 1'b0;
              last_q   <= 1'b0;
              busy_q   <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              t_q      <= '0;
              i_q      <= i_d;
              c_q      <= c_d;
              d_run_q  <= d_run_d;
              x_run_q  <= x_run_d;
              addr_d_q <= d_run_d;
              addr_x_q <= x_run_d;
              waddr_q  <= waddr_q + 1'b1;
              last_q   <= 1'b0;
              if (HAS_GAP) begin
                state_q <= S_GAP;
                gap_q   <= GAP_LAST;
                valid_q <= 1'b0;
                zero_q  <= 1'b0;
                first_q <= 1'b0;
              end else begin
                zero_q  <= mode_q;
                first_q <= 1'b1;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_q == '0) begin
            state_q <= S_RUN;
            valid_q <= 1'b1;
            zero_q  <= mode_q;
            first_q <= 1'b1;
          end else begin
            gap_q <= gap_q - 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_addr_d = addr_d_q;
  assign o_addr_x = addr_x_q;
  assign o_valid  = valid_q;
  assign o_zero   = zero_q;
  assign o_first  = first_q;
  assign o_last   = last_q;
  assign o_waddr  = waddr_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule
